// File: rtl/key_stream_reader.sv
// key_stream_reader: walks the stored AES round keys in stream order, reading
// each one from a fixed-latency key store and presenting it downstream with a
// valid/ready handshake.
//
// Handshake: key_out/key_idx/last are valid while key_valid=1 and stay stable
// until a rising edge where key_ready=1. key_ready has no effect while
// key_valid=0.
//
// Configuration macro KEY_ORDER_FWD_EN: when defined the stream runs 0..10
// (encryption order); otherwise it runs 10..0 (decryption order).
//
// If key_done drops mid-stream, the stream restarts from the first index once
// key_done returns. When key_done drops in the same cycle as a handshake, the
// abort wins and the key does not count as transferred.
module key_stream_reader #(
   parameter int LAT = 1  // key-store read latency in cycles, legal 1..3
) (
   input  logic         clk,
   input  logic         rest,
   input  logic         start,
   input  logic         key_done,
   input  logic [127:0] key_round_in,
   output logic [3:0]   rount_no,
   output logic [127:0] key_out,
   output logic [3:0]   key_idx,
   output logic         key_valid,
   input  logic         key_ready,
   output logic         last,
   output logic         busy
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_GEN = 3'd1,
      S_ISSUE    = 3'd2,
      S_WAIT_LAT = 3'd3,
      S_PRESENT  = 3'd4
   } state_t;

`ifdef KEY_ORDER_FWD_EN
   localparam logic [3:0] FIRST_IDX = 4'd0;
   localparam logic [3:0] LAST_IDX  = 4'd10;
`else
   localparam logic [3:0] FIRST_IDX = 4'd10;
   localparam logic [3:0] LAST_IDX  = 4'd0;
`endif

   // The capture edge comes LAT+1 edges after rount_no updates; the counter
   // is cleared on the update edge and counts one per WAIT_LAT cycle.
   localparam logic [1:0] LAT_CNT = LAT[1:0];

   state_t     state_q;
   logic [3:0] idx_q;
   logic [3:0] idx_d;
   logic [1:0] cnt_q;

   // Next stream index; saturates at the final index so it can never leave 0..10.
   always_comb begin
      idx_d = idx_q;
      if (idx_q != LAST_IDX) begin
`ifdef KEY_ORDER_FWD_EN
         idx_d = idx_q + 4'd1;
`else
         idx_d = idx_q - 4'd1;
`endif
      end
   end

   // Stream sequencer with all outputs registered.
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state_q   <= S_IDLE;
         idx_q     <= 4'd0;
         cnt_q     <= 2'd0;
         rount_no  <= 4'd0;
         key_out   <= '0;
         key_idx   <= 4'd0;
         key_valid <= 1'b0;
         last      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_WAIT_GEN;
                  idx_q   <= FIRST_IDX;
                  busy    <= 1'b1;
               end
            end

            S_WAIT_GEN: begin
               if (key_done) begin
                  state_q <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               if (!key_done) begin
                  state_q <= S_WAIT_GEN;
                  idx_q   <= FIRST_IDX;
               end else begin
                  rount_no <= idx_q;
                  cnt_q    <= 2'd0;
                  state_q  <= S_WAIT_LAT;
               end
            end

            S_WAIT_LAT: begin
               if (!key_done) begin
                  state_q <= S_WAIT_GEN;
                  idx_q   <= FIRST_IDX;
               end else if (cnt_q == LAT_CNT) begin
                  key_out   <= key_round_in;
                  key_idx   <= rount_no;
                  last      <= (rount_no == LAST_IDX);
                  key_valid <= 1'b1;
                  state_q   <= S_PRESENT;
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end

            S_PRESENT: begin
               if (!key_done) begin
                  key_valid <= 1'b0;
                  last      <= 1'b0;
                  idx_q     <= FIRST_IDX;
                  state_q   <= S_WAIT_GEN;
               end else if (key_ready) begin
                  key_valid <= 1'b0;
                  last      <= 1'b0;
                  if (last) begin
                     busy    <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     idx_q   <= idx_d;
                     state_q <= S_ISSUE;
                  end
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_stream_reader.sv
// Bench for key_stream_reader: directed scenarios followed by a randomized
// phase, with a queue-based reference model of the key stream.
module tb_key_stream_reader;

   parameter int LAT = 1;

`ifdef KEY_ORDER_FWD_EN
   localparam logic [3:0] FIRST = 4'd0;
   localparam logic [3:0] LASTI = 4'd10;
   localparam logic [3:0] AFTER7 = 4'd8;
`else
   localparam logic [3:0] FIRST = 4'd10;
   localparam logic [3:0] LASTI = 4'd0;
   localparam logic [3:0] AFTER7 = 4'd6;
`endif

   logic         clk = 1'b0;
   logic         rest = 1'b1;
   logic         start = 1'b0;
   logic         key_done = 1'b1;
   logic [127:0] key_round_in;
   logic [3:0]   rount_no;
   logic [127:0] key_out;
   logic [3:0]   key_idx;
   logic         key_valid;
   logic         key_ready = 1'b1;
   logic         last;
   logic         busy;

   key_stream_reader #(.LAT(LAT)) dut (
      .clk(clk), .rest(rest), .start(start), .key_done(key_done),
      .key_round_in(key_round_in), .rount_no(rount_no), .key_out(key_out),
      .key_idx(key_idx), .key_valid(key_valid), .key_ready(key_ready),
      .last(last), .busy(busy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- key store model ----------------
   logic [127:0] store [0:15];
   logic [127:0] pipe  [0:2];
   always @(posedge clk) begin
      pipe[0] <= store[rount_no];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
   end
   assign key_round_in = pipe[LAT-1];

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   logic [3:0]   exp_q[$];
   bit           model_busy = 0;
   bit           hold_exp = 0;
   logic [127:0] snap_key;
   logic [3:0]   snap_idx;
   logic         snap_last;

   task automatic load_full();
      exp_q.delete();
      for (int i = 0; i < 11; i++) begin
         if (FIRST == 4'd0) exp_q.push_back(4'(i));
         else exp_q.push_back(4'(10 - i));
      end
   endtask

   // Monitor: checks outputs produced by the previous edge, then advances the
   // model using the inputs that the coming edge will see.
   always @(negedge clk) begin : monitor
      logic [3:0] e;
      if (!rest) begin
         chk("rount_no_range", {127'd0, rount_no <= 4'd10}, 128'd1);
         chk("busy", {127'd0, busy}, {127'd0, model_busy});
         if (!model_busy) chk("valid_when_idle", {127'd0, key_valid}, 128'd0);
         if (hold_exp) begin
            chk("hold_valid", {127'd0, key_valid}, 128'd1);
            chk("hold_key", key_out, snap_key);
            chk("hold_idx", {124'd0, key_idx}, {124'd0, snap_idx});
            chk("hold_last", {127'd0, last}, {127'd0, snap_last});
         end
      end
      hold_exp  = !rest && key_valid && !key_ready && key_done;
      snap_key  = key_out;
      snap_idx  = key_idx;
      snap_last = last;
      if (rest) begin
         model_busy = 0;
         exp_q.delete();
      end else if (!model_busy) begin
         if (start) begin
            model_busy = 1;
            load_full();
         end
      end else if (!key_done) begin
         load_full();
      end else if (key_valid && key_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_key", {124'd0, key_idx}, 128'hFFFF);
         end else begin
            e = exp_q.pop_front();
            chk("key_idx", {124'd0, key_idx}, {124'd0, e});
            chk("key_out", key_out, store[e]);
            chk("last", {127'd0, last}, {127'd0, e == LASTI});
            if (e == LASTI) model_busy = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (key_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) chk("wait_valid_timeout", 128'd0, 128'd1);
   endtask

   task automatic wait_idle(input int max_cyc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (!model_busy && !busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) chk("wait_idle_timeout", 128'd0, 128'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      bit ok;
      bit bad;
      int hs_cyc[$];
      int cyc;
      for (int i = 0; i < 16; i++) store[i] = {$urandom(), $urandom(), $urandom(), $urandom()};

      // reset
      rest = 1'b1;
      repeat (3) tick();
      chk("rst_rount_no", {124'd0, rount_no}, 128'd0);
      chk("rst_key_out", key_out, 128'd0);
      chk("rst_key_idx", {124'd0, key_idx}, 128'd0);
      chk("rst_valid", {127'd0, key_valid}, 128'd0);
      chk("rst_last", {127'd0, last}, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      rest = 1'b0;
      tick();

      // full stream, ready tied high: one key every LAT+3 cycles
      key_done = 1'b1;
      key_ready = 1'b1;
      pulse_start();
      cyc = 0;
      while ((model_busy || busy) && cyc < 400) begin
         if (key_valid) hs_cyc.push_back(cyc);
         tick();
         cyc++;
      end
      chk("stream_len", 128'(hs_cyc.size()), 128'd11);
      for (int i = 1; i < hs_cyc.size(); i++)
         chk("key_spacing", 128'(hs_cyc[i] - hs_cyc[i-1]), 128'(LAT + 3));
      wait_idle(10);

      // start while key_done low: no read until key_done rises
      key_done = 1'b0;
      pulse_start();
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (key_valid || rount_no != 4'd0) bad = 1'b1;
         tick();
      end
      chk("no_read_before_done", {127'd0, bad}, 128'd0);
      key_done = 1'b1;
      cyc = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (key_valid) begin
            cyc = i;
            break;
         end
      end
      chk("first_capture_latency", 128'(cyc), 128'(LAT + 3));
      chk("first_idx", {124'd0, key_idx}, {124'd0, FIRST});
      wait_idle(400);

      // backpressure: stall 5 cycles on idx 7
      key_ready = 1'b0;
      pulse_start();
      for (int k = 0; k < 11; k++) begin
         wait_valid(20, ok);
         if (!ok) break;
         if (key_idx == 4'd7) begin
            repeat (5) tick();
            key_ready = 1'b1;
            tick();
            key_ready = 1'b0;
            wait_valid(20, ok);
            chk("after_stall_idx", {124'd0, key_idx}, {124'd0, AFTER7});
         end else begin
            key_ready = 1'b1;
            tick();
            key_ready = 1'b0;
         end
         if (!model_busy) break;
      end
      key_ready = 1'b1;
      wait_idle(400);

      // key_done drops while presenting idx 4
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (key_valid && key_idx == 4'd4) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("reached_idx4", {127'd0, ok}, 128'd1);
      key_done = 1'b0;
      key_ready = 1'b0;
      tick();
      chk("abort_valid_low", {127'd0, key_valid}, 128'd0);
      repeat (3) tick();
      key_done = 1'b1;
      key_ready = 1'b1;
      wait_valid(20, ok);
      chk("restart_idx", {124'd0, key_idx}, {124'd0, FIRST});
      wait_idle(400);

      // asynchronous reset in WAIT_LAT; start during reset ignored
      pulse_start();
      wait_valid(40, ok);
      tick();
      tick();
      #1;
      rest = 1'b1;
      start = 1'b1;
      #1;
      chk("arst_rount_no", {124'd0, rount_no}, 128'd0);
      chk("arst_key_out", key_out, 128'd0);
      chk("arst_valid", {127'd0, key_valid}, 128'd0);
      chk("arst_busy", {127'd0, busy}, 128'd0);
      tick();
      tick();
      rest = 1'b0;
      start = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (busy || key_valid) bad = 1'b1;
         tick();
      end
      chk("no_resume_after_rst", {127'd0, bad}, 128'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 19) == 0);
         key_ready = ($urandom_range(0, 9) < 7);
         if (key_done) key_done = ($urandom_range(0, 39) != 0);
         else key_done = ($urandom_range(0, 2) == 0);
         tick();
      end
      start = 1'b0;
      key_done = 1'b1;
      key_ready = 1'b1;
      wait_idle(400);
      chk("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_stream_reader.md
KEY_STREAM_READER -- requirements
Module: key_stream_reader

Interface
REQ-001 The block SHALL have one parameter: LAT, default 1, the key-store read latency in cycles from rount_no change to key_round_in valid (legal 1..3).
REQ-002 Port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 Port rest  input  1  reset, asynchronous and active-high.
REQ-004 Port start  input  1  one-cycle pulse requesting one full key stream.
REQ-005 Port key_done  input  1  done flag from the round-key generator; high means all 11 round keys are stored.
REQ-006 Port key_round_in  input  128  round key returned by the key store for the current rount_no.
REQ-007 Port rount_no  output  4  registered round index driven to the key store.
REQ-008 Port key_out  output  128  round key presented to the downstream datapath.
REQ-009 Port key_idx  output  4  round index of key_out.
REQ-010 Port key_valid  output  1  key_out/key_idx are valid.
REQ-011 Port key_ready  input  1  downstream accepts key_out when high together with key_valid.
REQ-012 Port last  output  1  high with key_valid on the final key of the stream.
REQ-013 Port busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT_GEN, ISSUE, WAIT_LAT and PRESENT.
REQ-015 IDLE: start=1 -> WAIT_GEN with the stream index loaded to the first index; start SHALL be ignored in every other state.
REQ-016 WAIT_GEN: remain until key_done=1, then -> ISSUE; a stream SHALL never issue a read before key_done=1.
REQ-017 ISSUE: register rount_no <= stream index, clear the latency counter, -> WAIT_LAT (one cycle).
REQ-018 WAIT_LAT: rount_no held constant; on the edge exactly LAT+1 cycles after the rount_no update, capture key_out <= key_round_in and key_idx <= rount_no, -> PRESENT.
REQ-019 PRESENT: key_valid=1; key_out, key_idx and last SHALL stay stable until the edge where key_ready=1.
REQ-020 On a handshake with last=0: step the index by one, -> ISSUE, key_valid=0 the next cycle (no back-to-back valid).
REQ-021 On a handshake with last=1: -> IDLE, key_valid=0 and busy=0 the next cycle.
REQ-022 The default order SHALL be 10,9,...,0 (decryption); last=1 exactly when key_idx equals the final index of the active order.
REQ-023 If key_done falls in ISSUE, WAIT_LAT or PRESENT, the stream SHALL abort: key_valid=0 next cycle, -> WAIT_GEN, index reloaded to the first index, and no key SHALL be presented for the aborted read.
REQ-024 key_ready while key_valid=0 SHALL have no effect.
REQ-025 Index arithmetic SHALL be 4-bit unsigned, with no wrap past 0 or 10; values 11..15 SHALL never appear on rount_no.

Reset
REQ-026 rest=1 SHALL immediately force state IDLE and rount_no=0, key_out=0, key_idx=0, key_valid=0, last=0, busy=0, latency counter 0, index 0, including in the middle of a stream.
REQ-027 After rest is released, the block SHALL wait for a new start pulse; no partial stream resumes.

Configuration
REQ-028 Macro KEY_ORDER_FWD_EN: when defined, the order SHALL be 0,1,...,10 (encryption) with last on key_idx=0xA.
REQ-029 When KEY_ORDER_FWD_EN is undefined, the order SHALL be 10 down to 0 with last on key_idx=0x0.
REQ-030 No other behaviour SHALL depend on the macro.

Verification
REQ-031 Default build, LAT=1, key_done=1, key_ready tied 1, start pulse -> 11 keys on key_idx A..0, each equal to the store content for that index, last only on idx 0, busy falls one cycle after.
REQ-032 key_done=0 for 20 cycles after start -> rount_no unchanged, key_valid=0; key_done rises -> first capture of idx 0xA exactly LAT+2 cycles after ISSUE.
REQ-033 key_ready held 0 for 5 cycles on idx 7 -> key_out/key_idx/last stable all 5 cycles; one transfer on release; next valid is idx 6.
REQ-034 key_done dropped while presenting idx 4 -> key_valid=0 next cycle; on key_done return, the stream restarts at idx 0xA.
REQ-035 rest asserted asynchronously in WAIT_LAT -> all outputs 0 before the next clock edge; a start during rest is ignored.
REQ-036 KEY_ORDER_FWD_EN defined, LAT=3 -> order 0..A, each capture 4 cycles after its rount_no update, last on idx 0xA.
